// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFO family: width functions and an elaboration-time parameter guard.
// The guard is a macro so any stream block can drop it into its own generate scope.
`ifndef STREAM_FIFO_PKG_SV
`define STREAM_FIFO_PKG_SV

`define STREAM_PARAM_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $fatal(1, msg); \
    end

package stream_fifo_pkg;

    function automatic int clog2_p1(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`endif

// File: rtl/stream_fifo_wm_ctrl.sv
// Modulo-DEPTH read/write pointers, explicit usage counter and watermark flags; flush beats any push/pop.
// Status flags are pure functions of registered state, so nothing here depends combinationally on ready_i.
module stream_fifo_wm_ctrl
    import stream_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    parameter int PTR_W     = ptr_width(DEPTH),
    parameter int USAGE_W   = clog2_p1(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               wr_en_i,
    input  logic               rd_en_i,
    output logic [PTR_W-1:0]   wr_ptr_o,
    output logic [PTR_W-1:0]   rd_ptr_o,
    output logic [USAGE_W-1:0] usage_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic               almost_empty_o
);

    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [USAGE_W-1:0] USAGE_MAX = USAGE_W'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [USAGE_W-1:0] usage_q, usage_d;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
        end else begin
            if (wr_en_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en_i) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_en_i, rd_en_i})
                2'b10:   usage_d = usage_q + 1'b1;
                2'b01:   usage_d = usage_q - 1'b1;
                default: usage_d = usage_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    assign wr_ptr_o       = wr_ptr_q;
    assign rd_ptr_o       = rd_ptr_q;
    assign usage_o        = usage_q;
    assign full_o         = (usage_q == USAGE_MAX);
    assign empty_o        = (usage_q == '0);
    assign almost_full_o  = (usage_q >= USAGE_W'(AFULL_TH));
    assign almost_empty_o = (usage_q <= USAGE_W'(AEMPTY_TH));

endmodule

// File: rtl/stream_fifo_wm.sv
// Ready/valid FIFO with watermarks: 1-cycle latency, or 0 when empty in fall-through mode.
// ready_o = ~full_o from registered state only; a pop while full frees a slot for the next cycle.
module stream_fifo_wm
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int AFULL_TH     = DEPTH - 1,
    parameter int AEMPTY_TH    = 1,
    parameter int PTR_W        = ptr_width(DEPTH),
    parameter int USAGE_W      = clog2_p1(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [USAGE_W-1:0]    usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    `STREAM_PARAM_CHECK(g_chk_depth, DEPTH >= 1, "stream_fifo_wm: DEPTH must be >= 1")
    `STREAM_PARAM_CHECK(g_chk_afull, (AFULL_TH >= 1) && (AFULL_TH <= DEPTH),
                        "stream_fifo_wm: AFULL_TH must be in 1..DEPTH")
    `STREAM_PARAM_CHECK(g_chk_aempty, (AEMPTY_TH >= 0) && (AEMPTY_TH < DEPTH),
                        "stream_fifo_wm: AEMPTY_TH must be in 0..DEPTH-1")

    logic                  push, pop, bypass, wr_en, rd_en;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign ready_o = ~full_o;
    assign valid_o = FALL_THROUGH ? (~empty_o | valid_i) : ~empty_o;
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;
    // A beat passing straight through an empty fall-through FIFO never touches storage.
    assign bypass  = FALL_THROUGH & empty_o & push & pop;
    assign wr_en   = push & ~bypass;
    assign rd_en   = pop & ~bypass;
    assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) mem_q[wr_ptr] <= data_i;
    end

    stream_fifo_wm_ctrl #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH),
        .PTR_W     (PTR_W),
        .USAGE_W   (USAGE_W)
    ) u_ctrl (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .wr_en_i        (wr_en),
        .rd_en_i        (rd_en),
        .wr_ptr_o       (wr_ptr),
        .rd_ptr_o       (rd_ptr),
        .usage_o        (usage_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
    );

endmodule

// File: tb/tb_stream_fifo_wm.sv
// Two DEPTH=5 instances (registered and fall-through) driven independently and checked against a queue model.
module tb_stream_fifo_wm;

    localparam int DW = 32;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          fa = 0, va = 0, ra = 0, fb = 0, vb = 0, rb = 0;
    logic [DW-1:0] da = '0, db = '0;
    logic          rdy_a, vo_a, fu_a, em_a, af_a, ae_a;
    logic          rdy_b, vo_b, fu_b, em_b, af_b, ae_b;
    logic [DW-1:0] do_a, do_b;
    logic [2:0]    us_a, us_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] q [2][$];

    stream_fifo_wm #(.DATA_WIDTH(DW), .DEPTH(D), .FALL_THROUGH(1'b0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(fa), .testmode_i(1'b0),
        .data_i(da), .valid_i(va), .ready_o(rdy_a),
        .data_o(do_a), .valid_o(vo_a), .ready_i(ra),
        .usage_o(us_a), .full_o(fu_a), .empty_o(em_a),
        .almost_full_o(af_a), .almost_empty_o(ae_a));

    stream_fifo_wm #(.DATA_WIDTH(DW), .DEPTH(D), .FALL_THROUGH(1'b1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_ft (
        .clk_i(clk), .rst_i(rst), .flush_i(fb), .testmode_i(1'b1),
        .data_i(db), .valid_i(vb), .ready_o(rdy_b),
        .data_o(do_b), .valid_o(vo_b), .ready_i(rb),
        .usage_o(us_b), .full_o(fu_b), .empty_o(em_b),
        .almost_full_o(af_b), .almost_empty_o(ae_b));

    task automatic chk(input string nm, input int id, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, id, $time, act, exp);
        end
    endtask

    // Reference behaviour: a plain queue of accepted beats, plus the handshake rules.
    task automatic model_port(input int id, input bit ft,
                              input logic vi, input logic [DW-1:0] di, input logic ri, input logic fl,
                              input logic vo, input logic [DW-1:0] dout, input logic ro,
                              input logic [2:0] us, input logic fu, input logic em,
                              input logic af, input logic ae);
        int cnt = q[id].size();
        bit exp_r = (cnt < D);
        bit exp_v = (cnt > 0) || (ft && vi);
        bit do_push, do_pop;
        chk("ready", id, 32'(ro), 32'(exp_r));
        chk("usage", id, 32'(us), 32'(cnt));
        chk("full",  id, 32'(fu), 32'(cnt == D));
        chk("empty", id, 32'(em), 32'(cnt == 0));
        chk("afull", id, 32'(af), 32'(cnt >= AF));
        chk("aempty", id, 32'(ae), 32'(cnt <= AE));
        chk("valid", id, 32'(vo), 32'(exp_v));
        if (exp_v) chk("data", id, dout, (cnt > 0) ? q[id][0] : di);
        if (fl) begin
            q[id].delete();
        end else begin
            do_push = vi && exp_r;
            do_pop  = exp_v && ri;
            if (do_pop && cnt > 0) void'(q[id].pop_front());
            if (do_push && !(do_pop && cnt == 0)) q[id].push_back(di);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q[0].delete();
            q[1].delete();
        end else begin
            model_port(0, 1'b0, va, da, ra, fa, vo_a, do_a, rdy_a, us_a, fu_a, em_a, af_a, ae_a);
            model_port(1, 1'b1, vb, db, rb, fb, vo_b, do_b, rdy_b, us_b, fu_b, em_b, af_b, ae_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vb = 1'b1;
        repeat (3) step();
        chk("rst_usage", 0, 32'(us_a), 0);
        chk("rst_empty", 0, 32'(em_a), 1);
        chk("rst_ready", 0, 32'(rdy_a), 1);
        chk("rst_full",  0, 32'(fu_a), 0);
        chk("rst_aempty", 0, 32'(ae_a), 1);
        chk("rst_afull", 0, 32'(af_a), 0);
        chk("rst_valid", 0, 32'(vo_a), 0);
        chk("rst_ft_valid", 1, 32'(vo_b), 1);
        vb = 1'b0;
        #1;
        chk("rst_ft_valid_lo", 1, 32'(vo_b), 0);
        rst = 1'b0;
        repeat (3) step();

        // Fill to full with the output stalled, then drain.
        ra = 1'b0;
        for (int i = 0; i < D; i++) begin
            va = 1'b1;
            da = 32'h11 + 32'(i);
            step();
            chk("fill_afull", 0, 32'(af_a), 32'(i >= AF - 1));
            chk("fill_full",  0, 32'(fu_a), 32'(i == D - 1));
        end
        va = 1'b0;
        chk("fill_usage", 0, 32'(us_a), D);
        ra = 1'b1;
        repeat (D + 1) step();
        ra = 1'b0;

        // Preload two, then stream 23 beats through to wrap the pointers several times.
        for (int i = 0; i < 2; i++) begin
            va = 1'b1; da = $urandom; step();
        end
        ra = 1'b1;
        for (int i = 0; i < 23; i++) begin
            da = $urandom;
            step();
            chk("stream_usage", 0, 32'(us_a), 2);
        end
        va = 1'b0;
        repeat (3) step();
        ra = 1'b0;

        // Full with simultaneous push and pop: only the pop is taken.
        for (int i = 0; i < D; i++) begin
            va = 1'b1; da = 32'hA0 + 32'(i); step();
        end
        da = 32'h99; ra = 1'b1;
        step();
        va = 1'b0; ra = 1'b0;
        chk("fullpp_usage", 0, 32'(us_a), D - 1);
        chk("fullpp_ready", 0, 32'(rdy_a), 1);
        ra = 1'b1;
        repeat (D + 1) step();
        ra = 1'b0;

        // Flush with a concurrent push: the pushed beat is dropped.
        for (int i = 0; i < 3; i++) begin
            va = 1'b1; da = 32'hC0 + 32'(i); step();
        end
        fa = 1'b1; da = 32'hEE;
        step();
        fa = 1'b0; va = 1'b0;
        chk("flush_usage", 0, 32'(us_a), 0);
        chk("flush_empty", 0, 32'(em_a), 1);
        ra = 1'b1;
        repeat (3) step();
        ra = 1'b0;

        // Fall-through bypass while empty.
        vb = 1'b1; db = 32'hAB; rb = 1'b1;
        #1;
        chk("ft_valid", 1, 32'(vo_b), 1);
        chk("ft_data",  1, do_b, 32'hAB);
        chk("ft_usage", 1, 32'(us_b), 0);
        step();
        chk("ft_usage_after", 1, 32'(us_b), 0);
        vb = 1'b0; rb = 1'b0;
        step();

        // Randomised traffic on both instances, with alternating ready bias and one reset mid-run.
        for (int c = 0; c < 3000; c++) begin
            bit slow = ((c / 150) % 2) == 1;
            va = ($urandom_range(0, 3) != 0);
            vb = ($urandom_range(0, 3) != 0);
            ra = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rb = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            da = $urandom;
            db = $urandom;
            fa = ($urandom_range(0, 60) == 0);
            fb = ($urandom_range(0, 60) == 0);
            rst = (c == 1500);
            step();
        end
        rst = 1'b0; va = 0; vb = 0; fa = 0; fb = 0; ra = 1; rb = 1;
        repeat (D + 2) step();
        chk("final_empty", 0, 32'(em_a), 1);
        chk("final_empty", 1, 32'(em_b), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
